// File: rtl/heartbeat_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// heartbeat_pattern_gen_if
// Bundles the board-control inputs and the display-multiplexer outputs of the
// heartbeat animation sequencer.
//   auto      : 1 = beat continuously (level)
//   trigger   : single-cycle pulse, starts one beat when idle
//   line[3:0] : per-digit bar side (bit i = digit i; 0 = left, 1 = right)
//   an_en[3:0]: per-digit enable (bit 3 = leftmost digit)
//   frame[1:0]: current frame index
//   busy      : beat in progress
//   beat_done : one-cycle pulse when a beat returns to frame 0
// master = the sequencer, slave = the side that drives auto/trigger and
// consumes the display signals.
// ---------------------------------------------------------------------------
interface heartbeat_pattern_gen_if;
   logic       auto;
   logic       trigger;
   logic [3:0] line;
   logic [3:0] an_en;
   logic [1:0] frame;
   logic       busy;
   logic       beat_done;

   modport master (
      input  auto, trigger,
      output line, an_en, frame, busy, beat_done
   );

   modport slave (
      output auto, trigger,
      input  line, an_en, frame, busy, beat_done
   );
endinterface

// File: rtl/heartbeat_pattern_gen.sv
// ---------------------------------------------------------------------------
// heartbeat_pattern_gen
// Steps four frames of vertical bars outward (0,1,2,3) and back (2,1) to form
// one heartbeat, each frame held FRAME_CYCLES clocks. Beats run continuously
// while auto is high, or one per trigger pulse from idle.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   hb_if  : heartbeat_pattern_gen_if.master (auto/trigger in,
//            line/an_en/frame/busy/beat_done out)
// Parameter:
//   FRAME_CYCLES : clocks per frame, >= 2
// ---------------------------------------------------------------------------
module heartbeat_pattern_gen #(
   parameter int FRAME_CYCLES = 1_388_889
) (
   input  logic                    clk,
   input  logic                    reset,
   heartbeat_pattern_gen_if.master hb_if
);

   localparam int CNT_W = $clog2(FRAME_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EXPAND   = 2'd1,
      S_CONTRACT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       frame_q, frame_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             done_q,  done_d;
   logic             tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         frame_q <= 2'd0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d   = '0;
            frame_d = 2'd0;
            // auto and trigger together still start only one beat
            if (hb_if.auto || hb_if.trigger) begin
               state_d = S_EXPAND;
            end
         end

         S_EXPAND: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
               if (frame_q == 2'd3) begin
                  frame_d = 2'd2;
                  state_d = S_CONTRACT;
               end else begin
                  frame_d = frame_q + 2'd1;
               end
            end
         end

         S_CONTRACT: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
               if (frame_q == 2'd1) begin
                  frame_d = 2'd0;
                  done_d  = 1'b1;
                  // auto is checked only at the end of a beat, so dropping it
                  // mid-beat lets the beat finish
                  state_d = hb_if.auto ? S_EXPAND : S_IDLE;
               end else begin
                  frame_d = frame_q - 2'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            frame_d = 2'd0;
            cnt_d   = '0;
         end
      endcase
   end

   // Display decode straight from the frame register: one edge per change.
   always_comb begin
      hb_if.an_en = 4'b0110;
      hb_if.line  = 4'b0100;
      unique case (frame_q)
         2'd0: begin hb_if.an_en = 4'b0110; hb_if.line = 4'b0100; end
         2'd1: begin hb_if.an_en = 4'b0110; hb_if.line = 4'b0010; end
         2'd2: begin hb_if.an_en = 4'b1001; hb_if.line = 4'b1000; end
         2'd3: begin hb_if.an_en = 4'b1001; hb_if.line = 4'b0001; end
         default: begin hb_if.an_en = 4'b0110; hb_if.line = 4'b0100; end
      endcase
   end

   assign hb_if.frame     = frame_q;
   assign hb_if.busy      = (state_q != S_IDLE);
   assign hb_if.beat_done = done_q;

endmodule
